// File: rtl/display_scan_ctrl_pkg.sv
// Shared definitions for the 7-segment scan controller: FSM encoding, digit defaults,
// BCD saturation limit and the refresh prescaler divisor.
package display_scan_ctrl_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CONV   = 2'd1,
    UPDATE = 2'd2
  } state_t;

  localparam int N_DIGITS_DEF = 4;
  localparam int BCD_MAX_DEF  = 9999;

  // Largest value representable with nDigits decimal digits (10^nDigits - 1).
  function automatic int bcdMax(input int nDigits);
    int m;
    m = 1;
    for (int i = 0; i < nDigits; i++) m = m * 10;
    return m - 1;
  endfunction

  function automatic int scanDiv(input int clkHz, input int refreshHz, input int nDigits);
    return clkHz / (refreshHz * nDigits);
  endfunction

endpackage

// File: rtl/display_scan_ctrl_bin2bcd.sv
// Sequential double-dabble core: a start pulse loads the binary word, then one
// add-3/shift iteration per clock; o_lastStep flags the cycle whose edge finishes it.
module bin2bcd_seq #(
  parameter int BIN_W    = 14,
  parameter int N_DIGITS = 4
) (
  input  logic                  CLK,
  input  logic                  reset,
  input  logic                  i_start,
  input  logic [BIN_W-1:0]      i_bin,
  output logic [4*N_DIGITS-1:0] o_bcd,
  output logic                  o_lastStep
);

  localparam int BCD_W = 4 * N_DIGITS;
  localparam int CW    = (BIN_W > 1) ? $clog2(BIN_W) : 1;

  logic [BIN_W-1:0] r_bin;
  logic [BCD_W-1:0] r_bcd;
  logic [BCD_W-1:0] w_adj;
  logic [CW-1:0]    r_cnt;
  logic             r_active;

  always_comb begin
    w_adj = r_bcd;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (r_bcd[4*i +: 4] >= 4'd5) w_adj[4*i +: 4] = r_bcd[4*i +: 4] + 4'd3;
    end
  end

  // The BCD accumulator shifts in the binary MSB each step, so {bcd, bin} acts as one register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_bin    <= '0;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b0;
    end else if (i_start) begin
      r_bin    <= i_bin;
      r_bcd    <= '0;
      r_cnt    <= '0;
      r_active <= 1'b1;
    end else if (r_active) begin
      r_bcd <= {w_adj[BCD_W-2:0], r_bin[BIN_W-1]};
      r_bin <= {r_bin[BIN_W-2:0], 1'b0};
      r_cnt <= r_cnt + 1'b1;
      if (r_cnt == CW'(BIN_W - 1)) r_active <= 1'b0;
    end
  end

  assign o_bcd      = r_bcd;
  assign o_lastStep = r_active && (r_cnt == CW'(BIN_W - 1));

endmodule

// File: rtl/display_scan_ctrl.sv
// Captures a binary value, converts it to BCD and time-multiplexes the digits onto numero/anodos.
// Optional build macro LEADING_ZERO_BLANK_EN turns off anodes above the most significant nonzero digit.
module display_scan_ctrl
  import display_scan_ctrl_pkg::*;
#(
  parameter int CLK_HZ     = 100_000_000,
  parameter int REFRESH_HZ = 1000,
  parameter int N_DIGITS   = N_DIGITS_DEF,
  parameter int BIN_W      = 14
) (
  input  logic                CLK,
  input  logic                reset,
  input  logic [BIN_W-1:0]    valor,
  input  logic                load,
  output logic [3:0]          numero,
  output logic [N_DIGITS-1:0] anodos,
  output logic                busy,
  output logic                overflow
);

  localparam int SCAN_DIV = scanDiv(CLK_HZ, REFRESH_HZ, N_DIGITS);
  localparam int PW       = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
  localparam int IW       = (N_DIGITS > 1) ? $clog2(N_DIGITS) : 1;
  localparam logic [BIN_W-1:0]    MAXV      = BIN_W'(bcdMax(N_DIGITS));
  localparam logic [N_DIGITS-1:0] ANODE_ONE = {{(N_DIGITS-1){1'b0}}, 1'b1};

  state_t                  r_state, w_next;
  logic                    w_start, w_update, w_lastStep;
  logic [BIN_W-1:0]        w_capVal, w_sat;
  logic [4*N_DIGITS-1:0]   w_bcd;
  logic [4*N_DIGITS-1:0]   r_disp;
  logic                    r_pending, r_busy, r_overflow;
  logic [BIN_W-1:0]        r_pendVal;
  logic [PW-1:0]           r_presc;
  logic [IW-1:0]           r_idx, r_idxD;
  logic                    w_tick;
  logic [3:0]              r_numero;
  logic [N_DIGITS-1:0]     r_anodos;

  always_ff @(posedge CLK) begin
    if (reset) r_state <= IDLE;
    else       r_state <= w_next;
  end

  // A load arriving during UPDATE, or one parked while converting, restarts conversion directly.
  always_comb begin
    w_next   = r_state;
    w_start  = 1'b0;
    w_update = 1'b0;
    w_capVal = valor;
    case (r_state)
      IDLE: begin
        if (load) begin
          w_start = 1'b1;
          w_next  = CONV;
        end
      end
      CONV: begin
        if (w_lastStep) w_next = UPDATE;
      end
      UPDATE: begin
        w_update = 1'b1;
        if (load || r_pending) begin
          w_start  = 1'b1;
          w_capVal = load ? valor : r_pendVal;
          w_next   = CONV;
        end else begin
          w_next = IDLE;
        end
      end
      default: w_next = IDLE;
    endcase
  end

  assign w_sat = (w_capVal > MAXV) ? MAXV : w_capVal;

  bin2bcd_seq #(.BIN_W(BIN_W), .N_DIGITS(N_DIGITS)) u_bin2bcd (
    .CLK        (CLK),
    .reset      (reset),
    .i_start    (w_start),
    .i_bin      (w_sat),
    .o_bcd      (w_bcd),
    .o_lastStep (w_lastStep)
  );

  always_ff @(posedge CLK) begin
    if (reset) begin
      r_disp     <= '0;
      r_pending  <= 1'b0;
      r_pendVal  <= '0;
      r_busy     <= 1'b0;
      r_overflow <= 1'b0;
    end else begin
      if (w_start) begin
        r_busy     <= 1'b1;
        r_overflow <= (w_capVal > MAXV);
      end else if (w_update) begin
        r_busy <= 1'b0;
      end
      if (w_update) r_disp <= w_bcd;
      if (r_state == CONV && load) begin
        r_pending <= 1'b1;
        r_pendVal <= valor;
      end else if (w_start) begin
        r_pending <= 1'b0;
      end
    end
  end

  assign w_tick = (r_presc == PW'(SCAN_DIV - 1));

`ifdef LEADING_ZERO_BLANK_EN
  logic [IW-1:0] w_msd;
  logic          r_blank;

  always_comb begin
    w_msd = '0;
    for (int i = 1; i < N_DIGITS; i++) begin
      if (r_disp[4*i +: 4] != 4'd0) w_msd = IW'(i);
    end
  end
`endif

  // anodos trails numero by one cycle to line up with the downstream code memory register.
  always_ff @(posedge CLK) begin
    if (reset) begin
      r_presc  <= '0;
      r_idx    <= '0;
      r_idxD   <= '0;
      r_numero <= 4'd0;
      r_anodos <= '1;
`ifdef LEADING_ZERO_BLANK_EN
      r_blank  <= 1'b0;
`endif
    end else begin
      r_presc <= w_tick ? '0 : r_presc + 1'b1;
      if (w_tick) r_idx <= (r_idx == IW'(N_DIGITS - 1)) ? '0 : r_idx + 1'b1;
      r_numero <= r_disp[{r_idx, 2'b00} +: 4];
      r_idxD   <= r_idx;
`ifdef LEADING_ZERO_BLANK_EN
      r_blank  <= (r_idx > w_msd);
      r_anodos <= r_blank ? '1 : ~(ANODE_ONE << r_idxD);
`else
      r_anodos <= ~(ANODE_ONE << r_idxD);
`endif
    end
  end

  assign numero   = r_numero;
  assign anodos   = r_anodos;
  assign busy     = r_busy;
  assign overflow = r_overflow;

endmodule
